// File: rtl/lsl_seq_if.sv
// Handshake and data bus of the sequential logical-shift-left unit.
// The master side issues start/data_in/shift_amount. The slave side (lsl_seq)
// returns the result, busy, done and carry_out.
interface lsl_seq_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] data_in;
    logic [N-1:0] shift_amount;
    logic [N-1:0] data_out;
    logic         busy;
    logic         done;
    logic         carry_out;

    modport master (
        output start, data_in, shift_amount,
        input  data_out, busy, done, carry_out
    );

    modport slave (
        input  start, data_in, shift_amount,
        output data_out, busy, done, carry_out
    );
endinterface

// File: rtl/lsl_seq.sv
// Sequential logical shift left: one bit position per clock.
// The shift count saturates at N, so large amounts give an all-zero result.
// Optional feature macro: LSL_SEQ_CARRY_EN. It enables the carry_out register,
// which holds the last bit shifted out of the MSB.
// Without the macro, carry_out is tied to 0.
module lsl_seq #(
    parameter int N = 4
) (
    input  logic     clk,
    input  logic     rst,
    lsl_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [N-1:0] NMAX = N[N-1:0];

    state_t       r_state;
    logic [N-1:0] r_work;
    logic [N-1:0] r_count;
    logic         r_busy;
    logic         r_done;
    logic [N-1:0] w_load_count;

`ifdef LSL_SEQ_CARRY_EN
    logic         r_carry;
    assign bus.carry_out = r_carry;
`else
    assign bus.carry_out = 1'b0;
`endif

    // Saturate the requested amount at N; shifting further changes nothing.
    assign w_load_count = (bus.shift_amount >= NMAX) ? NMAX : bus.shift_amount;

    assign bus.data_out = r_work;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

    // Control FSM plus the working, count and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef LSL_SEQ_CARRY_EN
            r_carry <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_work  <= bus.data_in;
                        r_count <= w_load_count;
                        r_busy  <= 1'b1;
`ifdef LSL_SEQ_CARRY_EN
                        r_carry <= 1'b0;
`endif
                        if (w_load_count == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_work  <= r_work << 1;
                    r_count <= r_count - 1'b1;
`ifdef LSL_SEQ_CARRY_EN
                    r_carry <= r_work[N-1];
`endif
                    if (r_count == {{(N-1){1'b0}}, 1'b1}) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsl_seq.sv
// Self-checking bench for lsl_seq.
// The expected result, carry and latency come from plain shift arithmetic.
// Stimulus is directed cases, a reset abort, and randomized operations.
// The random operations may re-pulse start while the unit is busy.
module tb_lsl_seq;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    lsl_seq_if #(.N(N)) bus ();

    lsl_seq #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation: start is applied at a negedge and sampled at the next posedge.
    // Afterwards every negedge is checked.
    // If poke is set, start is held high with random operands in every busy
    // cycle, including the DONE cycle. Those requests must all be ignored.
    task automatic do_op(input logic [N-1:0] d, input logic [N-1:0] s, input bit poke);
        int           k;
        logic [31:0]  full;
        logic [31:0]  r;
        logic [N-1:0] exp_d;
        logic         exp_c;
        bit           seen;
        k     = (int'(s) >= N) ? N : int'(s);
        full  = 32'(d) << k;
        exp_d = full[N-1:0];
`ifdef LSL_SEQ_CARRY_EN
        exp_c = full[N];
`else
        exp_c = 1'b0;
`endif
        @(negedge clk);
        bus.start        = 1'b1;
        bus.data_in      = d;
        bus.shift_amount = s;
        @(posedge clk);
        seen = 1'b0;
        for (int c = 1; c <= N + 4 && !seen; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                chk("latency", 32'(c), 32'(k + 1));
                chk("data_out", 32'(bus.data_out), 32'(exp_d));
                chk("carry_out", 32'(bus.carry_out), 32'(exp_c));
                chk("busy_in_done", 32'(bus.busy), 32'd1);
            end else begin
                chk("busy_in_shift", 32'(bus.busy), 32'd1);
            end
            if (poke) begin
                r                = $urandom;
                bus.start        = 1'b1;
                bus.data_in      = r[N-1:0];
                bus.shift_amount = r[2*N-1:N];
            end else begin
                bus.start = 1'b0;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("hold_data", 32'(bus.data_out), 32'(exp_d));
        chk("hold_carry", 32'(bus.carry_out), 32'(exp_c));
    endtask

    initial begin
        logic [31:0] r;
        bus.start        = 1'b1;
        bus.data_in      = 4'b1111;
        bus.shift_amount = 4'd2;
        rst              = 1'b1;
        // Reset state, with start held high to show that reset has priority.
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(bus.data_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_carry", 32'(bus.carry_out), 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;

        // Directed cases.
        do_op(4'b1011, 4'd1, 1'b0);
        do_op(4'b1011, 4'd0, 1'b0);
        do_op(4'b0001, 4'd6, 1'b0);
        do_op(4'b0111, 4'd3, 1'b1);
        do_op(4'b1000, 4'd4, 1'b0);
        do_op(4'b1111, 4'd15, 1'b1);

        // Reset on the second SHIFT cycle must abort without a done pulse.
        @(negedge clk);
        bus.start        = 1'b1;
        bus.data_in      = 4'b1111;
        bus.shift_amount = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_data", 32'(bus.data_out), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_carry", 32'(bus.carry_out), 32'd0);
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(bus.done), 32'd0);
        end
        do_op(4'b0011, 4'd2, 1'b0);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            do_op(r[N-1:0], r[2*N-1:N], r[8]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
